// File: rtl/sop_stage_pkg.sv
// Shared types for the SOP edge-capture slice: filter FSM states and the
// timestamped event record carried through the event FIFO.
package sop_stage_pkg;

  // Widest timestamp an event can carry; narrower counters are zero-extended.
  localparam int SOP_TS_W = 16;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } filt_state_t;

  typedef struct packed {
    logic                dir;
    logic [SOP_TS_W-1:0] ts;
  } sop_evt_t;

  // Build an event record from a direction bit and a timestamp.
  function automatic sop_evt_t make_evt(input logic dir, input logic [SOP_TS_W-1:0] ts);
    sop_evt_t v_evt;
    v_evt.dir = dir;
    v_evt.ts  = ts;
    return v_evt;
  endfunction

endpackage

// File: rtl/sop_evt_fifo.sv
// Event FIFO with a registered head. An entry becomes visible on the head one
// cycle after it is written. A push while full is taken only when the head is
// popped in the same cycle; otherwise it is dropped and flagged on o-side drop.
module sop_evt_fifo
  import sop_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     push,
  input  sop_evt_t push_data,
  input  logic     pop_ready,
  output logic     head_valid,
  output sop_evt_t head,
  output logic     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  sop_evt_t    r_mem [DEPTH];
  logic        r_head_valid;
  sop_evt_t    r_head;

  logic [AW:0] w_wr_ptr_nxt;
  logic [AW:0] w_rd_ptr_nxt;
  logic        w_full;
  logic        w_pop;
  logic        w_push_acc;
  logic        w_drop;
  logic        w_head_avail;

  // Derive full, pop/push acceptance and next pointers.
  always_comb begin
    w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop        = r_head_valid && pop_ready && !flush;
    w_push_acc   = push && !flush && (!w_full || w_pop);
    w_drop       = push && !flush && w_full && !w_pop;
    w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push_acc};
    w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};
    // Only entries already stored before this edge may reach the head.
    w_head_avail = (r_wr_ptr != w_rd_ptr_nxt);
  end

  // Read/write pointers, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Registered head: reload from the slot the read pointer will point at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_valid <= 1'b0;
      r_head       <= '0;
    end else if (flush) begin
      r_head_valid <= 1'b0;
      r_head       <= r_head;
    end else begin
      r_head_valid <= w_head_avail;
      if (w_head_avail) begin
        r_head <= r_mem[w_rd_ptr_nxt[AW-1:0]];
      end else begin
        r_head <= r_head;
      end
    end
  end

  assign head_valid = r_head_valid;
  assign head       = r_head;
  assign drop       = w_drop;

endmodule

// File: rtl/sop_edge_capture.sv
// Captures the SOP stage output: two-flop synchroniser, stability filter,
// saturating rise counter, free-running timestamp and an event FIFO of
// timestamped edges with a sticky overflow flag.
module sop_edge_capture
  import sop_stage_pkg::*;
#(
  parameter int FILT_LEN   = 4,
  parameter int CNT_W      = 8,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y_in,
  input  logic             clr,
  output logic             y_filt,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_dir,
  output logic [TS_W-1:0]  evt_ts,
  output logic             overflow
);

  localparam logic [3:0]       FILT_LEN_C = 4'(FILT_LEN);
  localparam logic [TS_W-1:0]  TS_ONE     = TS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             r_s1;
  logic             r_y_s;
  filt_state_t      r_state;
  logic [3:0]       r_fcnt;
  logic             r_y_filt;
  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_rise_cnt;
  logic             r_overflow;

  logic             w_rise;
  logic             w_fall;
  logic [3:0]       w_fcnt_inc;
  logic [TS_W-1:0]  w_ts_nxt;
  logic             w_push;
  sop_evt_t         w_push_evt;
  logic             w_head_valid;
  sop_evt_t         w_head;
  logic             w_drop;
  logic             w_unused_ts;

  // Plain two-flop synchroniser for the asynchronous SOP output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= 1'b0;
      r_y_s <= 1'b0;
    end else begin
      r_s1  <= y_in;
      r_y_s <= r_s1;
    end
  end

  // Decide whether the filter toggles on this edge (FILT_LEN = 1 skips PEND).
  always_comb begin
    w_rise     = 1'b0;
    w_fall     = 1'b0;
    w_fcnt_inc = r_fcnt + 4'd1;
    case (r_state)
      STABLE_LO: w_rise = r_y_s && (FILT_LEN_C == 4'd1);
      PEND_HI:   w_rise = r_y_s && (w_fcnt_inc == FILT_LEN_C);
      STABLE_HI: w_fall = !r_y_s && (FILT_LEN_C == 4'd1);
      PEND_LO:   w_fall = !r_y_s && (w_fcnt_inc == FILT_LEN_C);
      default: begin
        w_rise = 1'b0;
        w_fall = 1'b0;
      end
    endcase
  end

  // Stability filter FSM; clr deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= STABLE_LO;
      r_fcnt   <= 4'd0;
      r_y_filt <= 1'b0;
    end else begin
      case (r_state)
        STABLE_LO: begin
          if (w_rise) begin
            r_state  <= STABLE_HI;
            r_y_filt <= 1'b1;
            r_fcnt   <= 4'd0;
          end else if (r_y_s) begin
            r_state <= PEND_HI;
            r_fcnt  <= 4'd1;
          end else begin
            r_fcnt <= 4'd0;
          end
        end
        PEND_HI: begin
          if (w_rise) begin
            r_state  <= STABLE_HI;
            r_y_filt <= 1'b1;
            r_fcnt   <= 4'd0;
          end else if (r_y_s) begin
            r_fcnt <= w_fcnt_inc;
          end else begin
            r_state <= STABLE_LO;
            r_fcnt  <= 4'd0;
          end
        end
        STABLE_HI: begin
          if (w_fall) begin
            r_state  <= STABLE_LO;
            r_y_filt <= 1'b0;
            r_fcnt   <= 4'd0;
          end else if (!r_y_s) begin
            r_state <= PEND_LO;
            r_fcnt  <= 4'd1;
          end else begin
            r_fcnt <= 4'd0;
          end
        end
        PEND_LO: begin
          if (w_fall) begin
            r_state  <= STABLE_LO;
            r_y_filt <= 1'b0;
            r_fcnt   <= 4'd0;
          end else if (!r_y_s) begin
            r_fcnt <= w_fcnt_inc;
          end else begin
            r_state <= STABLE_HI;
            r_fcnt  <= 4'd0;
          end
        end
        default: begin
          r_state  <= STABLE_LO;
          r_y_filt <= 1'b0;
          r_fcnt   <= 4'd0;
        end
      endcase
    end
  end

  // Free-running timestamp, wraps naturally and ignores clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts <= '0;
    end else begin
      r_ts <= w_ts_nxt;
    end
  end

  // Event is stamped with the timestamp of the cycle in which y_filt changes.
  always_comb begin
    w_ts_nxt   = r_ts + TS_ONE;
    w_push     = (w_rise || w_fall) && !clr;
    w_push_evt = make_evt(w_rise, SOP_TS_W'(w_ts_nxt));
  end

  // Saturating count of filtered rising edges; clr wins over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise_cnt <= '0;
    end else if (clr) begin
      r_rise_cnt <= '0;
    end else if (w_rise && (r_rise_cnt != {CNT_W{1'b1}})) begin
      r_rise_cnt <= r_rise_cnt + CNT_ONE;
    end else begin
      r_rise_cnt <= r_rise_cnt;
    end
  end

  // Sticky overflow, set when the FIFO refuses an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  sop_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (clr),
    .push       (w_push),
    .push_data  (w_push_evt),
    .pop_ready  (evt_ready),
    .head_valid (w_head_valid),
    .head       (w_head),
    .drop       (w_drop)
  );

  // Timestamp bits above TS_W are always zero.
  assign w_unused_ts = ^(w_head.ts >> TS_W);

  assign y_filt    = r_y_filt;
  assign rise_cnt  = r_rise_cnt;
  assign evt_valid = w_head_valid;
  assign evt_dir   = w_head.dir;
  assign evt_ts    = w_head.ts[TS_W-1:0];
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_sop_edge_capture.sv
// Directed bench for sop_edge_capture with FILT_LEN=4, CNT_W=2, TS_W=4, DEPTH=4.
// Edge counter e counts clock edges since reset release; a toggle on edge n
// carries timestamp n mod 16.
module tb_sop_edge_capture;

  logic       clk;
  logic       rst_n;
  logic       y_in;
  logic       clr;
  logic       y_filt;
  logic [1:0] rise_cnt;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_dir;
  logic [3:0] evt_ts;
  logic       overflow;

  int n_cmp;
  int n_bad;
  int e;
  int t;
  int t6;
  int ts_r;
  int ts_f;
  int ov_ts [0:4];

  sop_edge_capture #(
    .FILT_LEN   (4),
    .CNT_W      (2),
    .TS_W       (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .y_in      (y_in),
    .clr       (clr),
    .y_filt    (y_filt),
    .rise_cnt  (rise_cnt),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_dir   (evt_dir),
    .evt_ts    (evt_ts),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  // Drive a new level and run to the edge on which the filter toggles.
  task automatic make_edge(input logic lvl, output int ts_o);
    y_in = lvl;
    repeat (6) tick();
    ts_o = e % 16;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_yfilt"}, y_filt, 0);
    check_val({tag, "_cnt"}, rise_cnt, 0);
    check_val({tag, "_valid"}, evt_valid, 0);
    check_val({tag, "_dir"}, evt_dir, 0);
    check_val({tag, "_ts"}, evt_ts, 0);
    check_val({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; e = 0;
    rst_n = 1'b0; y_in = 1'b0; clr = 1'b0; evt_ready = 1'b0;
    #1;
    check_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = 0;

    // Clean step: y_in rises before edge 10
    repeat (9) tick();
    y_in = 1'b1;
    repeat (5) tick();
    check_val("step_pre_yfilt", y_filt, 0);
    tick();
    check_val("step_yfilt", y_filt, 1);
    check_val("step_cnt", rise_cnt, 1);
    check_val("step_valid_lag", evt_valid, 0);
    tick();
    check_val("step_valid", evt_valid, 1);
    check_val("step_dir", evt_dir, 1);
    check_val("step_ts", evt_ts, 15);
    evt_ready = 1'b1;
    tick();
    check_val("step_pop", evt_valid, 0);
    evt_ready = 1'b0;

    // Falling edge back to low: toggles on edge 23 -> ts 7
    make_edge(1'b0, t);
    check_val("fall_yfilt", y_filt, 0);
    tick();
    check_val("fall_valid", evt_valid, 1);
    check_val("fall_dir", evt_dir, 0);
    check_val("fall_ts", evt_ts, 7);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;

    // Glitch of 3 cycles is rejected
    y_in = 1'b1;
    repeat (3) tick();
    y_in = 1'b0;
    repeat (8) tick();
    check_val("glitch_yfilt", y_filt, 0);
    check_val("glitch_valid", evt_valid, 0);
    check_val("glitch_cnt", rise_cnt, 1);

    // 4-cycle pulse gives a rise and a fall event
    y_in = 1'b1;
    ts_r = (e + 6) % 16;
    repeat (4) tick();
    y_in = 1'b0;
    ts_f = (e + 6) % 16;
    repeat (6) tick();
    check_val("pulse_yfilt", y_filt, 0);
    check_val("pulse_cnt", rise_cnt, 2);
    check_val("pulse_valid", evt_valid, 1);
    check_val("pulse_dir_r", evt_dir, 1);
    check_val("pulse_ts_r", evt_ts, ts_r);
    evt_ready = 1'b1;
    tick();
    check_val("pulse_valid_f", evt_valid, 1);
    check_val("pulse_dir_f", evt_dir, 0);
    check_val("pulse_ts_f", evt_ts, ts_f);
    tick();
    check_val("pulse_drained", evt_valid, 0);
    evt_ready = 1'b0;

    // Overflow: five edges into four slots
    make_edge(1'b1, ov_ts[0]);
    make_edge(1'b0, ov_ts[1]);
    make_edge(1'b1, ov_ts[2]);
    make_edge(1'b0, ov_ts[3]);
    check_val("ovf_not_yet", overflow, 0);
    make_edge(1'b1, ov_ts[4]);
    check_val("ovf_set", overflow, 1);
    check_val("ovf_sat_cnt", rise_cnt, 3);
    check_val("ovf_valid", evt_valid, 1);
    check_val("ovf_dir0", evt_dir, 1);
    check_val("ovf_ts0", evt_ts, ov_ts[0]);
    // Sixth edge lands while full, with a pop on the same edge
    y_in = 1'b0;
    t6 = (e + 6) % 16;
    repeat (5) tick();
    evt_ready = 1'b1;
    tick();
    check_val("ovf6_yfilt", y_filt, 0);
    check_val("ovf6_ovf", overflow, 1);
    check_val("ovf_dir1", evt_dir, 0);
    check_val("ovf_ts1", evt_ts, ov_ts[1]);
    tick();
    check_val("ovf_dir2", evt_dir, 1);
    check_val("ovf_ts2", evt_ts, ov_ts[2]);
    tick();
    check_val("ovf_dir3", evt_dir, 0);
    check_val("ovf_ts3", evt_ts, ov_ts[3]);
    tick();
    check_val("ovf_valid6", evt_valid, 1);
    check_val("ovf_dir6", evt_dir, 0);
    check_val("ovf_ts6", evt_ts, t6);
    tick();
    check_val("ovf_drained", evt_valid, 0);
    evt_ready = 1'b0;

    // Clear in the same cycle as a rising toggle
    make_edge(1'b1, t);
    make_edge(1'b0, t);
    tick();
    check_val("clr_pre_valid", evt_valid, 1);
    check_val("clr_pre_cnt", rise_cnt, 3);
    y_in = 1'b1;
    repeat (5) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_val("clr_yfilt", y_filt, 1);
    check_val("clr_cnt", rise_cnt, 0);
    check_val("clr_ovf", overflow, 0);
    check_val("clr_valid", evt_valid, 0);
    repeat (2) tick();
    check_val("clr_noqueue", evt_valid, 0);

    // Timestamp wrap: fall at ts 14, rise at ts 1
    while (((e + 6) % 16) != 14) tick();
    make_edge(1'b0, t);
    repeat (13) tick();
    make_edge(1'b1, t);
    tick();
    check_val("wrap_valid", evt_valid, 1);
    check_val("wrap_dir_a", evt_dir, 0);
    check_val("wrap_ts_a", evt_ts, 14);
    evt_ready = 1'b1;
    tick();
    check_val("wrap_dir_b", evt_dir, 1);
    check_val("wrap_ts_b", evt_ts, 1);
    tick();
    check_val("wrap_drained", evt_valid, 0);
    evt_ready = 1'b0;
    check_val("wrap_cnt", rise_cnt, 1);

    // Reset mid-operation with three events queued and the filter pending high
    make_edge(1'b0, t);
    make_edge(1'b1, t);
    make_edge(1'b0, t);
    tick();
    check_val("mid_pre_valid", evt_valid, 1);
    check_val("mid_pre_cnt", rise_cnt, 2);
    y_in = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = 0;
    repeat (5) tick();
    check_val("rel_pre_yfilt", y_filt, 0);
    tick();
    check_val("rel_yfilt", y_filt, 1);
    check_val("rel_cnt", rise_cnt, 1);
    tick();
    check_val("rel_valid", evt_valid, 1);
    check_val("rel_dir", evt_dir, 1);
    check_val("rel_ts", evt_ts, 6);
    evt_ready = 1'b1;
    tick();
    check_val("rel_drained", evt_valid, 0);
    evt_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
